// File: rtl/ga_pkg.sv
// Shared types and helpers for the successor active-node manager.
package ga_pkg;

  localparam int unsigned MaxNa = 64;

  typedef enum logic [1:0] {
    StIdle,
    StProc,
    StFim
  } ga_state_e;

  // Width of a counter that must hold 0..n inclusive.
  function automatic int unsigned largura_livres(input int unsigned n);
    return $clog2(n + 1);
  endfunction

  // Index of the lowest set bit; 0 when the vector is empty.
  function automatic int menor_bit(input logic [MaxNa-1:0] v);
    menor_bit = 0;
    for (int i = int'(MaxNa) - 1; i >= 0; i--) begin
      if (v[i]) menor_bit = i;
    end
  endfunction

endpackage

// File: rtl/ga_prioridade_livre.sv
// Lowest free slot finder plus free-slot count over an occupancy vector.
module ga_prioridade_livre import ga_pkg::*; #(
  parameter int unsigned NumNa = 8,
  parameter int unsigned IdxW  = $clog2(NumNa),
  parameter int unsigned CntW  = largura_livres(NumNa)
) (
  input  logic [NumNa-1:0] ocup_i,
  output logic [IdxW-1:0]  idx_o,
  output logic             valid_o,
  output logic [CntW-1:0]  livres_o
);

  logic [NumNa-1:0] livre;

  assign livre   = ~ocup_i;
  assign valid_o = |livre;
  assign idx_o   = IdxW'(menor_bit(MaxNa'(livre)));

  always_comb begin
    livres_o = '0;
    for (int i = 0; i < int'(NumNa); i++) begin
      livres_o = livres_o + CntW'(livre[i]);
    end
  end

endmodule

// File: rtl/gerenciador_ativos_seq.sv
// Successor active-node manager: applies a burst of neighbour candidates to the NA bank,
// updating hits in place and allocating the lowest free slot on misses.
module gerenciador_ativos_seq import ga_pkg::*; #(
  parameter int unsigned NUM_NA          = 8,
  parameter int unsigned NUM_EA          = 8,
  parameter int unsigned ADDR_WIDTH      = 5,
  parameter int unsigned CUSTO_WIDTH     = 4,
  parameter int unsigned DISTANCIA_WIDTH = 5,
  parameter bit          SO_MENOR        = 1'b1
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic                              fonte_valid_in,
  input  logic [ADDR_WIDTH-1:0]             fonte_endereco_in,
  input  logic [NUM_NA-1:0]                 desativar_in,
  input  logic                              req_valid_in,
  output logic                              req_ready_out,
  input  logic [NUM_EA-1:0]                 vizinho_valido_in,
  input  logic [ADDR_WIDTH*NUM_EA-1:0]      endereco_in,
  input  logic [CUSTO_WIDTH*NUM_EA-1:0]     menor_vizinho_in,
  input  logic [DISTANCIA_WIDTH*NUM_EA-1:0] distancia_in,
  input  logic [ADDR_WIDTH-1:0]             anterior_in,
  input  logic [ADDR_WIDTH*NUM_NA-1:0]      na_endereco_in,
  input  logic [DISTANCIA_WIDTH*NUM_NA-1:0] na_distancia_in,
  input  logic [NUM_NA-1:0]                 na_ativo_in,
  output logic [NUM_NA-1:0]                 ga_habilitar_out,
  output logic [ADDR_WIDTH-1:0]             ga_endereco_out,
  output logic [CUSTO_WIDTH-1:0]            ga_menor_vizinho_out,
  output logic [DISTANCIA_WIDTH-1:0]        ga_distancia_out,
  output logic [NUM_NA-1:0]                 ga_desativar_out,
  output logic                              ga_atualizar_out,
  output logic [ADDR_WIDTH-1:0]             ga_anterior_out,
  output logic [$clog2(NUM_NA+1)-1:0]       ga_livres_out,
  output logic                              ga_overflow_out,
  output logic                              ga_ocupado_o
);

  localparam int unsigned KW = (NUM_EA > 1) ? $clog2(NUM_EA) : 1;
  localparam int unsigned IW = $clog2(NUM_NA);
  localparam int unsigned LW = largura_livres(NUM_NA);

  ga_state_e state_q, state_d;
  logic [KW-1:0] k_q, k_d;
  logic [NUM_NA-1:0] pend_q, pend_d;
  logic lat_load;

  logic [NUM_NA-1:0]          snap_ocup_q;
  logic [ADDR_WIDTH-1:0]      snap_end_q  [NUM_NA];
  logic [DISTANCIA_WIDTH-1:0] snap_dist_q [NUM_NA];

  logic [NUM_EA-1:0]          lat_val_q;
  logic [ADDR_WIDTH-1:0]      lat_end_q  [NUM_EA];
  logic [CUSTO_WIDTH-1:0]     lat_cus_q  [NUM_EA];
  logic [DISTANCIA_WIDTH-1:0] lat_dist_q [NUM_EA];
  logic [ADDR_WIDTH-1:0]      lat_ant_q;

  logic [NUM_NA-1:0]          hab_q, hab_d, desat_q, desat_d;
  logic [ADDR_WIDTH-1:0]      end_q, end_d, ant_q, ant_d;
  logic [CUSTO_WIDTH-1:0]     cus_q, cus_d;
  logic [DISTANCIA_WIDTH-1:0] dist_q, dist_d;
  logic                       atual_q, atual_d, ovf_q, ovf_d;
  logic [LW-1:0]              livres_q, livres_d;

  logic                       cand_val;
  logic [ADDR_WIDTH-1:0]      cand_end;
  logic [CUSTO_WIDTH-1:0]     cand_cus;
  logic [DISTANCIA_WIDTH-1:0] cand_dist;
  logic [NUM_NA-1:0]          hit_vec;
  logic [IW-1:0]              hit_idx;

  logic [NUM_NA-1:0] ocup_vista;
  logic [IW-1:0]     livre_idx;
  logic              livre_ok;
  logic [LW-1:0]     livres_cnt;
  logic              escrever;
  logic [IW-1:0]     alvo;

  assign cand_val  = lat_val_q[k_q];
  assign cand_end  = lat_end_q[k_q];
  assign cand_cus  = lat_cus_q[k_q];
  assign cand_dist = lat_dist_q[k_q];

  // Hits are resolved against the snapshot only, never against slots pending this burst.
  always_comb begin
    hit_vec = '0;
    for (int j = 0; j < int'(NUM_NA); j++) begin
      hit_vec[j] = snap_ocup_q[j] && (snap_end_q[j] == cand_end);
    end
  end

  assign hit_idx = IW'(menor_bit(MaxNa'(hit_vec)));

  // Idle tracks the live bank; during a burst the view is snapshot plus pending.
  assign ocup_vista = (state_q == StIdle) ? na_ativo_in : (snap_ocup_q | pend_q);

  ga_prioridade_livre #(
    .NumNa (NUM_NA),
    .IdxW  (IW),
    .CntW  (LW)
  ) u_prioridade (
    .ocup_i   (ocup_vista),
    .idx_o    (livre_idx),
    .valid_o  (livre_ok),
    .livres_o (livres_cnt)
  );

  always_comb begin
    state_d  = state_q;
    k_d      = k_q;
    pend_d   = pend_q;
    ovf_d    = ovf_q;
    lat_load = 1'b0;
    hab_d    = '0;
    desat_d  = '0;
    atual_d  = 1'b0;
    end_d    = end_q;
    cus_d    = cus_q;
    dist_d   = dist_q;
    ant_d    = ant_q;
    livres_d = livres_cnt;
    escrever = 1'b0;
    alvo     = '0;

    unique case (state_q)
      StIdle: begin
        if (fonte_valid_in) begin
          hab_d   = NUM_NA'(1);
          end_d   = fonte_endereco_in;
          cus_d   = '0;
          dist_d  = '0;
          atual_d = 1'b1;
          ant_d   = '0;
        end else if (|desativar_in) begin
          desat_d = desativar_in;
        end else if (req_valid_in) begin
          lat_load = 1'b1;
          pend_d   = '0;
          k_d      = '0;
          state_d  = StProc;
        end
      end

      StProc: begin
        if (cand_val) begin
          if (|hit_vec) begin
            if (!SO_MENOR || (cand_dist < snap_dist_q[hit_idx])) begin
              escrever = 1'b1;
              alvo     = hit_idx;
            end
          end else if (livre_ok) begin
            escrever         = 1'b1;
            alvo             = livre_idx;
            pend_d[livre_idx] = 1'b1;
            livres_d         = livres_cnt - LW'(1);
          end else begin
            ovf_d = 1'b1;
          end
        end
        if (escrever) begin
          hab_d[alvo] = 1'b1;
          end_d       = cand_end;
          cus_d       = cand_cus;
          dist_d      = cand_dist;
        end
        if (k_q == KW'(NUM_EA - 1)) begin
          state_d = StFim;
        end else begin
          k_d = k_q + KW'(1);
        end
      end

      StFim: begin
        atual_d = 1'b1;
        ant_d   = lat_ant_q;
        state_d = StIdle;
      end

      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= StIdle;
      k_q      <= '0;
      pend_q   <= '0;
      ovf_q    <= 1'b0;
      hab_q    <= '0;
      desat_q  <= '0;
      atual_q  <= 1'b0;
      end_q    <= '0;
      cus_q    <= '0;
      dist_q   <= '0;
      ant_q    <= '0;
      livres_q <= LW'(NUM_NA);
    end else begin
      state_q  <= state_d;
      k_q      <= k_d;
      pend_q   <= pend_d;
      ovf_q    <= ovf_d;
      hab_q    <= hab_d;
      desat_q  <= desat_d;
      atual_q  <= atual_d;
      end_q    <= end_d;
      cus_q    <= cus_d;
      dist_q   <= dist_d;
      ant_q    <= ant_d;
      livres_q <= livres_d;
    end
  end

  // Burst payload and snapshot registers carry no reset: they are always loaded before use.
  always_ff @(posedge clk) begin
    if (lat_load) begin
      lat_val_q   <= vizinho_valido_in;
      lat_ant_q   <= anterior_in;
      snap_ocup_q <= na_ativo_in;
      for (int i = 0; i < int'(NUM_EA); i++) begin
        lat_end_q[i]  <= endereco_in[i*ADDR_WIDTH +: ADDR_WIDTH];
        lat_cus_q[i]  <= menor_vizinho_in[i*CUSTO_WIDTH +: CUSTO_WIDTH];
        lat_dist_q[i] <= distancia_in[i*DISTANCIA_WIDTH +: DISTANCIA_WIDTH];
      end
      for (int j = 0; j < int'(NUM_NA); j++) begin
        snap_end_q[j]  <= na_endereco_in[j*ADDR_WIDTH +: ADDR_WIDTH];
        snap_dist_q[j] <= na_distancia_in[j*DISTANCIA_WIDTH +: DISTANCIA_WIDTH];
      end
    end
  end

  assign req_ready_out        = (state_q == StIdle);
  assign ga_ocupado_o         = (state_q != StIdle);
  assign ga_habilitar_out     = hab_q;
  assign ga_endereco_out      = end_q;
  assign ga_menor_vizinho_out = cus_q;
  assign ga_distancia_out     = dist_q;
  assign ga_desativar_out     = desat_q;
  assign ga_atualizar_out     = atual_q;
  assign ga_anterior_out      = ant_q;
  assign ga_livres_out        = livres_q;
  assign ga_overflow_out      = ovf_q;

endmodule

// File: tb/tb_gerenciador_ativos_seq.sv
// Two instances (SO_MENOR=0 and 1) share stimulus; each is checked against a burst-level model.
module tb_gerenciador_ativos_seq;

  localparam int NA = 4;
  localparam int EA = 3;
  localparam int AW = 5;
  localparam int CW = 4;
  localparam int DW = 5;
  localparam int LW = $clog2(NA + 1);

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic             fonte_valid_in = 1'b0;
  logic [AW-1:0]    fonte_endereco_in = '0;
  logic [NA-1:0]    desativar_in = '0;
  logic             req_valid_in = 1'b0;
  logic [EA-1:0]    vizinho_valido_in = '0;
  logic [AW*EA-1:0] endereco_in = '0;
  logic [CW*EA-1:0] menor_vizinho_in = '0;
  logic [DW*EA-1:0] distancia_in = '0;
  logic [AW-1:0]    anterior_in = '0;
  logic [AW*NA-1:0] na_endereco_in = '0;
  logic [DW*NA-1:0] na_distancia_in = '0;
  logic [NA-1:0]    na_ativo_in = '0;

  logic [1:0]          ready, atual, ovf, ocup;
  logic [1:0][NA-1:0]  hab, desat;
  logic [1:0][AW-1:0]  gend, gant;
  logic [1:0][CW-1:0]  gcus;
  logic [1:0][DW-1:0]  gdist;
  logic [1:0][LW-1:0]  livres;

  for (genvar g = 0; g < 2; g++) begin : g_dut
    gerenciador_ativos_seq #(
      .NUM_NA          (NA),
      .NUM_EA          (EA),
      .ADDR_WIDTH      (AW),
      .CUSTO_WIDTH     (CW),
      .DISTANCIA_WIDTH (DW),
      .SO_MENOR        (1'(g))
    ) u_dut (
      .clk                  (clk),
      .rst                  (rst),
      .fonte_valid_in       (fonte_valid_in),
      .fonte_endereco_in    (fonte_endereco_in),
      .desativar_in         (desativar_in),
      .req_valid_in         (req_valid_in),
      .req_ready_out        (ready[g]),
      .vizinho_valido_in    (vizinho_valido_in),
      .endereco_in          (endereco_in),
      .menor_vizinho_in     (menor_vizinho_in),
      .distancia_in         (distancia_in),
      .anterior_in          (anterior_in),
      .na_endereco_in       (na_endereco_in),
      .na_distancia_in      (na_distancia_in),
      .na_ativo_in          (na_ativo_in),
      .ga_habilitar_out     (hab[g]),
      .ga_endereco_out      (gend[g]),
      .ga_menor_vizinho_out (gcus[g]),
      .ga_distancia_out     (gdist[g]),
      .ga_desativar_out     (desat[g]),
      .ga_atualizar_out     (atual[g]),
      .ga_anterior_out      (gant[g]),
      .ga_livres_out        (livres[g]),
      .ga_overflow_out      (ovf[g]),
      .ga_ocupado_o         (ocup[g])
    );
  end

  int n_chk = 0;
  int n_err = 0;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Burst description and model state
  logic [NA-1:0] s_act;
  logic [AW-1:0] s_end  [NA];
  logic [DW-1:0] s_dist [NA];
  logic [EA-1:0] b_val;
  logic [AW-1:0] b_end  [EA];
  logic [CW-1:0] b_cus  [EA];
  logic [DW-1:0] b_dist [EA];
  logic [AW-1:0] b_ant;
  logic [NA-1:0] exp_hab [2][EA];
  int            exp_livres;
  logic          ovf_exp = 1'b0;

  task automatic model_burst();
    for (int m = 0; m < 2; m++) begin
      logic [NA-1:0] pend;
      int usados;
      pend = '0;
      for (int k = 0; k < EA; k++) begin
        exp_hab[m][k] = '0;
        if (b_val[k]) begin
          int hit;
          int fr;
          hit = -1;
          fr  = -1;
          for (int j = NA - 1; j >= 0; j--) if (s_act[j] && s_end[j] == b_end[k]) hit = j;
          if (hit >= 0) begin
            if (m == 0 || b_dist[k] < s_dist[hit]) exp_hab[m][k][hit] = 1'b1;
          end else begin
            for (int j = NA - 1; j >= 0; j--) if (!s_act[j] && !pend[j]) fr = j;
            if (fr >= 0) begin
              pend[fr] = 1'b1;
              exp_hab[m][k][fr] = 1'b1;
            end else begin
              ovf_exp = 1'b1;
            end
          end
        end
      end
      usados = 0;
      for (int j = 0; j < NA; j++) if (s_act[j] || pend[j]) usados++;
      exp_livres = NA - usados;
    end
  endtask

  task automatic drive_burst();
    for (int k = 0; k < EA; k++) begin
      endereco_in[k*AW +: AW]      = b_end[k];
      menor_vizinho_in[k*CW +: CW] = b_cus[k];
      distancia_in[k*DW +: DW]     = b_dist[k];
    end
    for (int j = 0; j < NA; j++) begin
      na_endereco_in[j*AW +: AW]  = s_end[j];
      na_distancia_in[j*DW +: DW] = s_dist[j];
    end
    na_ativo_in       = s_act;
    vizinho_valido_in = b_val;
    anterior_in       = b_ant;
    req_valid_in      = 1'b1;
  endtask

  task automatic run_burst(input string nome);
    model_burst();
    drive_burst();
    for (int c = 1; c <= EA + 2; c++) begin
      @(negedge clk);
      req_valid_in = 1'b0;
      for (int m = 0; m < 2; m++) begin
        logic [NA-1:0] eh;
        int k;
        k  = c - 2;
        eh = (c >= 2 && c <= EA + 1) ? exp_hab[m][k] : '0;
        check_eq($sformatf("%s hab s%0d c%0d", nome, m, c), 32'(hab[m]), 32'(eh));
        if (eh != '0) begin
          check_eq($sformatf("%s end s%0d c%0d", nome, m, c), 32'(gend[m]), 32'(b_end[k]));
          check_eq($sformatf("%s cus s%0d c%0d", nome, m, c), 32'(gcus[m]), 32'(b_cus[k]));
          check_eq($sformatf("%s dist s%0d c%0d", nome, m, c), 32'(gdist[m]), 32'(b_dist[k]));
        end
        check_eq($sformatf("%s ready s%0d c%0d", nome, m, c), 32'(ready[m]), 32'(c == EA + 2));
        check_eq($sformatf("%s atual s%0d c%0d", nome, m, c), 32'(atual[m]), 32'(c == EA + 2));
        if (c == EA + 2) begin
          check_eq($sformatf("%s anterior s%0d", nome, m), 32'(gant[m]), 32'(b_ant));
          check_eq($sformatf("%s livres s%0d", nome, m), 32'(livres[m]), 32'(exp_livres));
          check_eq($sformatf("%s overflow s%0d", nome, m), 32'(ovf[m]), 32'(ovf_exp));
        end
      end
    end
  endtask

  task automatic set_na(input logic [NA-1:0] act, input int a0, input int d0, input int a1,
                        input int a2);
    s_act = act;
    for (int j = 0; j < NA; j++) begin
      s_end[j]  = AW'(20 + j);
      s_dist[j] = '1;
    end
    s_end[0]  = AW'(a0);
    s_dist[0] = DW'(d0);
    s_end[1]  = AW'(a1);
    s_end[2]  = AW'(a2);
  endtask

  task automatic set_cand(input logic [EA-1:0] v, input int e0, input int d0, input int e1,
                          input int d1, input int e2, input int d2);
    b_val = v;
    b_end[0] = AW'(e0); b_dist[0] = DW'(d0); b_cus[0] = CW'(3);
    b_end[1] = AW'(e1); b_dist[1] = DW'(d1); b_cus[1] = CW'(6);
    b_end[2] = AW'(e2); b_dist[2] = DW'(d2); b_cus[2] = CW'(9);
    b_ant = AW'(17);
  endtask

  task automatic rand_burst();
    s_act = NA'($urandom);
    for (int j = 0; j < NA; j++) begin
      s_end[j]  = AW'($urandom_range(0, 7));
      s_dist[j] = DW'($urandom_range(0, 15));
    end
    b_val = EA'($urandom) | EA'($urandom);
    for (int k = 0; k < EA; k++) begin
      bit dup;
      do begin
        b_end[k] = AW'($urandom_range(0, 9));
        dup = 1'b0;
        for (int i = 0; i < k; i++) if (b_end[i] == b_end[k]) dup = 1'b1;
      end while (dup);
      b_dist[k] = DW'($urandom_range(0, 15));
      b_cus[k]  = CW'($urandom);
    end
    b_ant = AW'($urandom);
  endtask

  initial begin
    repeat (2) @(negedge clk);
    for (int m = 0; m < 2; m++) begin
      check_eq($sformatf("rst ready s%0d", m), 32'(ready[m]), 32'd1);
      check_eq($sformatf("rst livres s%0d", m), 32'(livres[m]), 32'(NA));
      check_eq($sformatf("rst hab s%0d", m), 32'(hab[m]), 32'd0);
      check_eq($sformatf("rst ovf s%0d", m), 32'(ovf[m]), 32'd0);
      check_eq($sformatf("rst ocup s%0d", m), 32'(ocup[m]), 32'd0);
    end
    rst = 1'b0;

    // Source load
    fonte_valid_in = 1'b1;
    fonte_endereco_in = AW'(5);
    @(negedge clk);
    fonte_valid_in = 1'b0;
    check_eq("fonte hab", 32'(hab[1]), 32'h1);
    check_eq("fonte end", 32'(gend[1]), 32'd5);
    check_eq("fonte dist", 32'(gdist[1]), 32'd0);
    check_eq("fonte cus", 32'(gcus[1]), 32'd0);
    check_eq("fonte atual", 32'(atual[1]), 32'd1);
    check_eq("fonte ant", 32'(gant[1]), 32'd0);
    @(negedge clk);
    check_eq("fonte hab off", 32'(hab[1]), 32'h0);
    check_eq("fonte atual off", 32'(atual[1]), 32'd0);

    set_na(4'b0001, 5, 9, 0, 0);
    set_cand(3'b111, 5, 4, 7, 6, 8, 2);
    run_burst("hitmiss");

    set_na(4'b0001, 5, 3, 0, 0);
    set_cand(3'b001, 5, 4, 1, 1, 2, 2);
    run_burst("so_menor");

    set_na(4'b0001, 5, 4, 0, 0);
    set_cand(3'b001, 5, 4, 1, 1, 2, 2);
    run_burst("empate");

    set_na(4'b0111, 1, 1, 2, 3);
    set_cand(3'b111, 10, 1, 11, 2, 12, 3);
    run_burst("overflow");

    set_na(4'b0000, 0, 0, 0, 0);
    set_cand(3'b010, 4, 1, 6, 2, 9, 3);
    run_burst("parcial");

    // Priority: fonte wins over desativar and req
    fonte_valid_in = 1'b1;
    fonte_endereco_in = AW'(9);
    desativar_in = 4'b0010;
    req_valid_in = 1'b1;
    @(negedge clk);
    fonte_valid_in = 1'b0;
    req_valid_in = 1'b0;
    check_eq("prio hab", 32'(hab[0]), 32'h1);
    check_eq("prio end", 32'(gend[0]), 32'd9);
    check_eq("prio desat", 32'(desat[0]), 32'd0);
    check_eq("prio ready", 32'(ready[0]), 32'd1);
    @(negedge clk);
    desativar_in = '0;
    check_eq("desat pulse", 32'(desat[0]), 32'h2);
    check_eq("desat ready", 32'(ready[0]), 32'd1);
    @(negedge clk);
    check_eq("desat off", 32'(desat[0]), 32'h0);

    // Idle free count follows the live bank
    na_ativo_in = 4'b1010;
    @(negedge clk);
    check_eq("livres idle", 32'(livres[0]), 32'd2);

    for (int it = 0; it < 40; it++) begin
      rand_burst();
      run_burst($sformatf("rnd%0d", it));
    end

    // Reset mid-burst
    set_na(4'b0000, 0, 0, 0, 0);
    set_cand(3'b111, 1, 1, 2, 2, 3, 3);
    drive_burst();
    @(negedge clk);
    req_valid_in = 1'b0;
    @(negedge clk);
    check_eq("abort first write", 32'(hab[1]), 32'h1);
    rst = 1'b1;
    ovf_exp = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    for (int c = 0; c < 4; c++) begin
      check_eq($sformatf("abort hab c%0d", c), 32'(hab[1]), 32'h0);
      check_eq($sformatf("abort ready c%0d", c), 32'(ready[1]), 32'd1);
      check_eq($sformatf("abort atual c%0d", c), 32'(atual[1]), 32'd0);
      check_eq($sformatf("abort ovf c%0d", c), 32'(ovf[1]), 32'(ovf_exp));
      @(negedge clk);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_err);
    $finish;
  end

endmodule
